// File: rtl/nn_pkg.sv
// Shared types, default widths and the saturation helper for the neuron lanes.
// Activation encodings are fixed by the cfg_act field of the layer config.
package nn_pkg;

  localparam int NN_IN_W       = 16;
  localparam int NN_FRAC       = 15;
  localparam int NN_OUT_W      = 16;
  localparam int NN_ACC_W      = 40;
  localparam int NN_LANES      = 4;
  localparam int NN_MAX_INPUTS = 1024;
  localparam int SAT_W         = 64;

  typedef enum logic [1:0] {
    ACT_ID     = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_RELU_B = 2'b11
  } act_e;

  // Clamp v into the signed range of an ow-bit word.
  function automatic logic signed [SAT_W-1:0] sat(
    input logic signed [SAT_W-1:0] v,
    input int                      ow
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/neuron_lane.sv
// One neuron lane: accumulator, post-scale, activation and saturation.
// NEURON_LANES_LEAKY_EN enables the 1/8-slope leaky path for ACT_LEAKY.
module neuron_lane
  import nn_pkg::*;
#(
  parameter int IN_W  = NN_IN_W,
  parameter int FRAC  = NN_FRAC,
  parameter int OUT_W = NN_OUT_W,
  parameter int ACC_W = NN_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat_i,
  input  logic                   last_i,
  input  logic signed [IN_W-1:0] data_i,
  input  logic signed [IN_W-1:0] weight_i,
  input  logic signed [IN_W-1:0] bias_i,
  input  act_e                   act_i,
  output logic [OUT_W-1:0]       res_o
);

  logic signed [2*IN_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  bias_x;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  r;
  logic signed [ACC_W-1:0]  v;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [OUT_W-1:0]         res_q;
  logic [OUT_W-1:0]         res_d;

  assign prod   = data_i * weight_i;
  assign prod_x = ACC_W'(prod);
  assign bias_x = ACC_W'(bias_i) <<< FRAC;
  assign sum    = acc_q + prod_x + bias_x;
  assign r      = sum >>> FRAC;

  // Activation on the full-width scaled sum, ahead of saturation.
  always_comb begin
    v = r;
    unique case (1'b1)
      act_i == ACT_ID: v = r;
      act_i == ACT_LEAKY: begin
`ifdef NEURON_LANES_LEAKY_EN
        v = r[ACC_W-1] ? (r >>> 3) : r;
`else
        v = r[ACC_W-1] ? '0 : r;
`endif
      end
      default: v = r[ACC_W-1] ? '0 : r;
    endcase
  end

  // Next-state: accumulate on middle beats, emit and clear on the last.
  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (beat_i) begin
      if (last_i) begin
        acc_d = '0;
        res_d = OUT_W'(sat(SAT_W'(v), OUT_W));
      end else begin
        acc_d = acc_q + prod_x;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/neuron_lanes.sv
// LANES parallel MAC neurons sharing one activation stream, valid/ready both sides.
// Define NEURON_LANES_LEAKY_EN to make cfg_act=10 a leaky ReLU (else ReLU).
module neuron_lanes
  import nn_pkg::*;
#(
  parameter  int IN_W       = NN_IN_W,
  parameter  int FRAC       = NN_FRAC,
  parameter  int OUT_W      = NN_OUT_W,
  parameter  int ACC_W      = NN_ACC_W,
  parameter  int LANES      = NN_LANES,
  parameter  int MAX_INPUTS = NN_MAX_INPUTS,
  localparam int CNT_W      = $clog2(MAX_INPUTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          data_in,
  input  logic [LANES*IN_W-1:0]    weight_in,
  input  logic [LANES*IN_W-1:0]    bias_in,
  input  logic [CNT_W-1:0]         cfg_num_inputs,
  input  logic [1:0]               cfg_act,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   data_out,
  output logic                     busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] n_d;
  logic [CNT_W-1:0] n_clamp;
  logic [CNT_W-1:0] n_cur;
  act_e             act_q;
  act_e             act_d;
  act_e             act_cur;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             first;
  logic             last;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (cnt_q == '0);
  assign n_cur    = first ? n_clamp : n_q;
  assign act_cur  = first ? act_e'(cfg_act) : act_q;
  assign last     = (cnt_q == n_cur - CNT_W'(1));

  // Keep the set length within 1..MAX_INPUTS.
  always_comb begin
    n_clamp = cfg_num_inputs;
    if (cfg_num_inputs == '0)
      n_clamp = CNT_W'(1);
    else if (cfg_num_inputs > CNT_W'(MAX_INPUTS))
      n_clamp = CNT_W'(MAX_INPUTS);
  end

  // Beat counter, config latch and output-valid next state.
  always_comb begin
    cnt_d       = cnt_q;
    n_d         = n_q;
    act_d       = act_q;
    out_valid_d = out_valid_q;
    if (out_ready)
      out_valid_d = 1'b0;
    if (accept) begin
      if (first) begin
        n_d   = n_clamp;
        act_d = act_cur;
      end
      if (last) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      n_q         <= '0;
      act_q       <= ACT_ID;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      act_q       <= act_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    neuron_lane #(
      .IN_W  (IN_W),
      .FRAC  (FRAC),
      .OUT_W (OUT_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .beat_i   (accept),
      .last_i   (last),
      .data_i   (data_in),
      .weight_i (weight_in[i*IN_W +: IN_W]),
      .bias_i   (bias_in[i*IN_W +: IN_W]),
      .act_i    (act_cur),
      .res_o    (data_out[i*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_neuron_lanes.sv
// Scoreboard bench for neuron_lanes: model pushes expected vectors, monitor pops.
// Honours NEURON_LANES_LEAKY_EN for the leaky activation expectation.
module tb_neuron_lanes;

  localparam int LANES = 4;
  localparam int CNT_W = 11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          data_in;
  logic [LANES*16-1:0]  weight_in;
  logic [LANES*16-1:0]  bias_in;
  logic [CNT_W-1:0]     cfg_num_inputs;
  logic [1:0]           cfg_act;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*16-1:0]  data_out;
  logic                 busy;

  always #5 clk = ~clk;

  neuron_lanes dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .weight_in      (weight_in),
    .bias_in        (bias_in),
    .cfg_num_inputs (cfg_num_inputs),
    .cfg_act        (cfg_act),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .busy           (busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_got;
  longint      macc[LANES];
  int          mcnt;
  int          mn;
  logic [1:0]  mact;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < LANES; l++) macc[l] = 0;
    mcnt = 0;
    mn   = 1;
    mact = 2'b00;
    exp_q.delete();
  endfunction

  function automatic longint act_sat(input longint r, input logic [1:0] a);
    longint v;
    case (a)
      2'b00: v = r;
`ifdef NEURON_LANES_LEAKY_EN
      2'b10: v = (r < 0) ? (r >>> 3) : r;
`endif
      default: v = (r < 0) ? 0 : r;
    endcase
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic void model_beat(input logic [15:0] d,
                                     input logic [63:0] wv,
                                     input logic [63:0] bv,
                                     input int ncfg,
                                     input logic [1:0] a);
    logic [63:0] res;
    longint      p;
    longint      s;
    longint      v;
    bit          is_last;
    res = '0;
    if (mcnt == 0) begin
      mn   = (ncfg == 0) ? 1 : ((ncfg > 1024) ? 1024 : ncfg);
      mact = a;
    end
    is_last = (mcnt == mn - 1);
    for (int l = 0; l < LANES; l++) begin
      p = longint'($signed(d)) * longint'($signed(wv[l*16 +: 16]));
      if (is_last) begin
        s = macc[l] + p + (longint'($signed(bv[l*16 +: 16])) <<< 15);
        v = act_sat(s >>> 15, mact);
        res[l*16 +: 16] = v[15:0];
        macc[l] = 0;
      end else begin
        macc[l] = macc[l] + p;
      end
    end
    if (is_last) begin
      exp_q.push_back(res);
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endfunction

  // Monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        check("data_out", data_out, exp_q.pop_front());
        last_got = data_out;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [63:0] wv,
                      input logic [63:0] bv, input int ncfg,
                      input logic [1:0] a);
    bit ok;
    data_in        = d;
    weight_in      = wv;
    bias_in        = bv;
    cfg_num_inputs = CNT_W'(ncfg);
    cfg_act        = a;
    in_valid       = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk);
      #1;
      model_beat(d, wv, bv, ncfg, a);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  logic [63:0] w_act;
  logic [15:0] lk_exp;

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    out_ready      = 1'b1;
    data_in        = '0;
    weight_in      = '0;
    bias_in        = '0;
    cfg_num_inputs = '0;
    cfg_act        = 2'b00;
    last_got       = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Basic single-beat set
    send(16'h4000, rep(16'h4000), '0, 1, 2'b01);
    drain();
    check("basic", last_got, rep(16'h2000));

    // Four-beat accumulate with bias
    for (int b = 0; b < 4; b++) begin
      send(16'h2000, rep(16'h2000), rep(16'h1000), 4, 2'b01);
      check("acc_busy", 64'(busy), (b < 3) ? 64'd1 : 64'd0);
    end
    drain();
    check("accumulate", last_got, rep(16'h3000));

    // Activations on a negative lane 0
    w_act = {16'h4000, 16'h4000, 16'h4000, 16'hC000};
    send(16'h4000, w_act, '0, 1, 2'b01);
    drain();
    check("act_relu", 64'(last_got[15:0]), 64'h0000);
    send(16'h4000, w_act, '0, 1, 2'b00);
    drain();
    check("act_id", 64'(last_got[15:0]), 64'hE000);
    send(16'h4000, w_act, '0, 1, 2'b10);
    drain();
`ifdef NEURON_LANES_LEAKY_EN
    lk_exp = 16'hFC00;
`else
    lk_exp = 16'h0000;
`endif
    check("act_leaky", 64'(last_got[15:0]), 64'(lk_exp));
    check("act_leaky_pos", 64'(last_got[31:16]), 64'h2000);

    // Saturation both directions
    for (int b = 0; b < 8; b++) send(16'h7FFF, rep(16'h7FFF), '0, 8, 2'b01);
    drain();
    check("sat_pos", last_got, rep(16'h7FFF));
    for (int b = 0; b < 8; b++) send(16'h7FFF, rep(16'h8001), '0, 8, 2'b00);
    drain();
    check("sat_neg", last_got, rep(16'h8000));

    // Zero count clamps to one beat
    send(16'h4000, rep(16'h4000), '0, 0, 2'b01);
    check("clamp_busy", 64'(busy), 64'd0);
    drain();
    check("clamp_zero", last_got, rep(16'h2000));

    // Back-pressure: result held, next beat stalled, then same-cycle restart
    out_ready = 1'b0;
    send(16'h4000, rep(16'h4000), '0, 1, 2'b01);
    data_in        = 16'h2000;
    weight_in      = rep(16'h2000);
    bias_in        = '0;
    cfg_num_inputs = CNT_W'(1);
    cfg_act        = 2'b00;
    in_valid       = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold", data_out, rep(16'h2000));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    model_beat(16'h2000, rep(16'h2000), '0, 1, 2'b00);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_data", data_out, rep(16'h0800));
    @(posedge clk);
    #1;
    drain();

    // Reset mid-set discards the partial sum
    send(16'h4000, rep(16'h4000), '0, 4, 2'b01);
    send(16'h4000, rep(16'h4000), '0, 4, 2'b01);
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check("rst_mid_busy", 64'(busy), 64'd0);
    send(16'h4000, rep(16'h4000), '0, 1, 2'b01);
    drain();
    check("rst_fresh", last_got, rep(16'h2000));

    // Random sets with gaps; config on later beats must be ignored
    for (int s = 0; s < 12; s++) begin
      int          n;
      logic [1:0]  a;
      logic [63:0] bv;
      n  = $urandom_range(1, 6);
      a  = 2'($urandom_range(0, 3));
      bv = {$urandom, $urandom};
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        send(16'($urandom), {$urandom, $urandom}, bv,
             (b == 0) ? n : $urandom_range(0, 9),
             (b == 0) ? a : 2'($urandom_range(0, 3)));
      end
      drain();
    end

    repeat (3) @(posedge clk);
    check("sb_empty_end", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
